// File: rtl/float_dot_acc.sv
`default_nettype none
// ============================================================================
// Module   : float_dot_acc
// Purpose  : Streaming floating-point dot-product accumulator. Sums the
//            products of one vector (terminated by in_last, or cut at
//            MAX_LEN) and presents the total on a valid/ready output port.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            in_valid/in_ready/in_data/in_last  - product stream
//            out_valid/out_ready         - result handshake
//            out_data                    - accumulated sum
//            out_count                   - number of products summed
//            out_overflow                - vector cut at MAX_LEN
// Revision : 1.0 - initial release
// ============================================================================
module float_dot_acc #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int BIAS      = -127,
    parameter int MAX_LEN   = 16,
    parameter int CNT_WIDTH = $clog2(MAX_LEN + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   out_data,
    output logic [CNT_WIDTH-1:0]           out_count,
    output logic                           out_overflow
);

    localparam int W       = EXP_WIDTH + MAN_WIDTH + 1;
    // Significand working width: hidden bit + mantissa + guard/round/sticky.
    localparam int SW      = MAN_WIDTH + 4;
    localparam int EXP_MAX = (1 << EXP_WIDTH) - 1;
    localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]         QNAN_BIT = W'(1) << (MAN_WIDTH - 1);

    // Both addends share the same bias, so it cancels out of the addition.
    // It is carried only so the parameter set matches the rest of the datapath.
    localparam logic [31:0] BIAS_BITS = 32'(BIAS);
    logic w_unused_bias;
    assign w_unused_bias = ^BIAS_BITS;

    // ------------------------------------------------------------------------
    // Combinational float add, round-to-nearest-even, with IEEE-style
    // handling of zeros, denormals, infinities and NaNs.
    // ------------------------------------------------------------------------
    function automatic logic [W-1:0] float_add(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic                 sa, sb, a_big, sbig, eff_sub, lost, found, round_up;
        logic                 nan_a, nan_b, inf_a, inf_b;
        logic [EXP_WIDTH-1:0] ea, eb;
        logic [MAN_WIDTH-1:0] ma, mb;
        logic [MAN_WIDTH:0]   fbig, fsmall;
        int                   xa, xb, xbig, xsmall, diff, lz, shift, exp_r;
        logic [SW-1:0]        big_ext, small_ext, small_sh, norm;
        logic [SW:0]          sum;
        logic [MAN_WIDTH+1:0] mant;
        logic [W-1:0]         res;

        sa = a[W-1];
        ea = a[W-2:MAN_WIDTH];
        ma = a[MAN_WIDTH-1:0];
        sb = b[W-1];
        eb = b[W-2:MAN_WIDTH];
        mb = b[MAN_WIDTH-1:0];

        nan_a = (ea == EXP_ONES) && (ma != '0);
        nan_b = (eb == EXP_ONES) && (mb != '0);
        inf_a = (ea == EXP_ONES) && (ma == '0);
        inf_b = (eb == EXP_ONES) && (mb == '0);

        // Denormals behave as exponent 1 with a zero hidden bit.
        xa = (ea == '0) ? 1 : int'(ea);
        xb = (eb == '0) ? 1 : int'(eb);

        // Order operands by magnitude so the subtraction never goes negative.
        a_big  = {ea, ma} >= {eb, mb};
        sbig   = a_big ? sa : sb;
        fbig   = a_big ? {ea != '0, ma} : {eb != '0, mb};
        fsmall = a_big ? {eb != '0, mb} : {ea != '0, ma};
        xbig   = a_big ? xa : xb;
        xsmall = a_big ? xb : xa;
        diff   = xbig - xsmall;

        big_ext   = {fbig, 3'b000};
        small_ext = {fsmall, 3'b000};
        lost      = 1'b0;
        if (diff >= SW) begin
            small_sh = {{(SW-1){1'b0}}, |fsmall};
        end else begin
            small_sh    = small_ext >> diff;
            lost        = |(small_ext & ((SW'(1) << diff) - SW'(1)));
            small_sh[0] = small_sh[0] | lost;
        end

        eff_sub = sa ^ sb;
        sum = eff_sub ? ({1'b0, big_ext} - {1'b0, small_sh})
                      : ({1'b0, big_ext} + {1'b0, small_sh});

        // Normalise: one right shift on carry-out, otherwise left shift by
        // the leading-zero count but never below exponent 1 (denormal range).
        lz    = 0;
        found = 1'b0;
        shift = 0;
        if (sum[SW]) begin
            norm  = {sum[SW:2], sum[1] | sum[0]};
            exp_r = xbig + 1;
        end else begin
            for (int i = SW - 1; i >= 0; i--) begin
                if (!found) begin
                    if (sum[i]) found = 1'b1;
                    else        lz    = lz + 1;
                end
            end
            shift = (lz < xbig) ? lz : xbig - 1;
            norm  = sum[SW-1:0] << shift;
            exp_r = xbig - shift;
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant     = {1'b0, norm[SW-1:3]} + {{(MAN_WIDTH+1){1'b0}}, round_up};
        if (mant[MAN_WIDTH+1]) begin
            mant  = mant >> 1;
            exp_r = exp_r + 1;
        end

        if (nan_a)
            res = a | QNAN_BIT;
        else if (nan_b)
            res = b | QNAN_BIT;
        else if (inf_a && inf_b && (sa != sb))
            res = {1'b0, EXP_ONES, 1'b1, {(MAN_WIDTH-1){1'b0}}};
        else if (inf_a)
            res = a;
        else if (inf_b)
            res = b;
        else if (sum == '0)
            res = {sa & sb, {(W-1){1'b0}}};  // x + (-x) gives +0
        else if (exp_r >= EXP_MAX)
            res = {sbig, EXP_ONES, {MAN_WIDTH{1'b0}}};
        else
            // A clear hidden bit means the result stayed denormal.
            res = {sbig,
                   mant[MAN_WIDTH] ? exp_r[EXP_WIDTH-1:0] : {EXP_WIDTH{1'b0}},
                   mant[MAN_WIDTH-1:0]};
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_ACC   = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [W-1:0]           r_acc;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [W-1:0]           w_sum;
    logic [CNT_WIDTH-1:0]   w_count_next;
    logic                   w_accept;
    logic                   w_len_hit;

    assign w_sum        = float_add(r_acc, in_data);
    assign w_count_next = r_count + CNT_WIDTH'(1);
    assign w_len_hit    = (w_count_next == CNT_WIDTH'(MAX_LEN));
    assign in_ready     = rst_n && (r_state != S_DONE);
    assign w_accept     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FIRST;
            r_acc        <= '0;
            r_count      <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_FIRST: begin
                    if (w_accept) begin
                        // Load directly so a -0 product keeps its sign.
                        r_acc   <= in_data;
                        r_count <= CNT_WIDTH'(1);
                        if (in_last || (MAX_LEN == 1)) begin
                            r_state      <= S_DONE;
                            out_valid    <= 1'b1;
                            out_data     <= in_data;
                            out_count    <= CNT_WIDTH'(1);
                            out_overflow <= !in_last;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        r_acc   <= w_sum;
                        r_count <= w_count_next;
                        if (in_last || w_len_hit) begin
                            r_state      <= S_DONE;
                            out_valid    <= 1'b1;
                            out_data     <= w_sum;
                            out_count    <= w_count_next;
                            out_overflow <= !in_last;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state   <= S_FIRST;
                        r_acc     <= '0;
                        r_count   <= '0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_FIRST;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_float_dot_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_dot_acc
// Purpose  : Directed self-checking bench for float_dot_acc (MAX_LEN = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_dot_acc;

    localparam int MAX_LEN = 4;
    localparam int CW      = $clog2(MAX_LEN + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [CW-1:0] out_count;
    logic          out_overflow;

    int errors = 0;
    int checks = 0;

    float_dot_acc #(
        .EXP_WIDTH (8),
        .MAN_WIDTH (23),
        .BIAS      (-127),
        .MAX_LEN   (MAX_LEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 50) else begin
            errors++;
            $error("FAIL send_timeout: observed=%0d expected=<50 cycles", n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] d,
                                 input int c, input logic o);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_count"}, 32'(out_count), 32'(c));
        chk({tag, "_ovf"}, 32'(out_overflow), 32'(o));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1 rst_n  = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_ovf", 32'(out_overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // 1 + 2 + 3 = 6
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b1);
        expect_result("sum3", 32'h40C00000, 3, 1'b0);
        chk("sum3_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("sum3_in_ready_back", 32'(in_ready), 32'd1);
        chk("sum3_valid_gone", 32'(out_valid), 32'd0);

        // Single beat after idle gap, then 1.0 + 0.5
        repeat (3) @(negedge clk);
        send(32'h3F000000, 1'b1);
        expect_result("single", 32'h3F000000, 1, 1'b0);
        drain("single");
        send(32'h3F800000, 1'b0);
        send(32'h3F000000, 1'b1);
        expect_result("onehalf", 32'h3FC00000, 2, 1'b0);
        drain("onehalf");

        // Negative zero first product keeps its sign
        send(32'h80000000, 1'b1);
        expect_result("negzero", 32'h80000000, 1, 1'b0);
        drain("negzero");

        // Back-pressure: 2 + 3 = 5 held while a beat waits upstream
        out_ready = 1'b0;
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b1);
        expect_result("bp", 32'h40A00000, 2, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h41000000;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", out_data, 32'h40A00000);
            chk("bp_hold_count", 32'(out_count), 32'd2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_released", 32'(out_valid), 32'd0);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        send(32'h3F800000, 1'b1);
        expect_result("bp_next", 32'h41100000, 2, 1'b0);
        drain("bp_next");

        // Overflow cut at MAX_LEN = 4, fifth beat starts a new vector
        for (int i = 0; i < 4; i++) send(32'h3F800000, 1'b0);
        expect_result("ovf_cut", 32'h40800000, 4, 1'b1);
        send(32'h3F800000, 1'b1);
        expect_result("ovf_tail", 32'h3F800000, 1, 1'b0);
        drain("ovf_tail");

        // in_last exactly at MAX_LEN is not an overflow
        for (int i = 0; i < 3; i++) send(32'h40000000, 1'b0);
        send(32'h40000000, 1'b1);
        expect_result("exact_len", 32'h41000000, 4, 1'b0);
        drain("exact_len");

        // Infinity propagates
        send(32'h3F800000, 1'b0);
        send(32'h7F800000, 1'b0);
        send(32'h40000000, 1'b1);
        expect_result("inf", 32'h7F800000, 3, 1'b0);
        drain("inf");

        // NaN propagates
        send(32'h3F800000, 1'b0);
        send(32'h7FFFFFFF, 1'b0);
        send(32'h40000000, 1'b1);
        chk("nan_valid", 32'(out_valid), 32'd1);
        chk("nan_exp", 32'(out_data[30:23]), 32'hFF);
        chk("nan_man_nonzero", 32'(|out_data[22:0]), 32'd1);
        drain("nan");

        // Reset in the middle of a vector
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_data", out_data, 32'h0);
        chk("midrst_count", 32'(out_count), 32'd0);
        chk("midrst_ovf", 32'(out_overflow), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send(32'h40000000, 1'b1);
        expect_result("after_rst", 32'h40000000, 1, 1'b0);
        drain("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/float_dot_acc.md
Name: float_dot_acc

Overview:
- Sequential floating-point accumulator that sits directly downstream of float_mul in the matmul datapath.
- Consumes a stream of products (one per accepted beat) and sums one vector's products into a single dot-product result.
- Presents that result on a valid/ready output port.
- Additions use the team's combinational float_add with the same FLOAT_BIAS_PARAMS, so rounding and special values match the rest of the datapath.

Parameters:
- EXP_WIDTH, 8, exponent field width; forwarded to float_add.
- MAN_WIDTH, 23, mantissa field width; forwarded to float_add.
- BIAS, -127, codebase bias parameter; forwarded to float_add unchanged.
- MAX_LEN, 16, maximum products per vector before forced completion; legal range 1 to 65535.
- CNT_WIDTH, $clog2(MAX_LEN+1), width of the element counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  EXP_WIDTH+MAN_WIDTH+1  product from float_mul.
- in_last  in  1  beat is the final product of the vector.
- out_valid  out  1  dot-product result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  EXP_WIDTH+MAN_WIDTH+1  accumulated sum.
- out_count  out  CNT_WIDTH  number of products summed into out_data.
- out_overflow  out  1  vector was cut at MAX_LEN without seeing in_last.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=S_FIRST; acc=0; count=0.
  - out_valid=0, out_data=0, out_count=0, out_overflow=0.
  - in_ready is driven 0 while rst_n is low.
- Handshakes:
  - Input beat accepted when in_valid && in_ready at a rising edge.
  - Output accepted when out_valid && out_ready.
  - in_ready = (state != S_DONE), combinational from state only; never from in_valid.
  - in_data, in_last, out_data, out_count and out_overflow must be stable while out_valid is high.
- States:
  - S_FIRST: waiting for the first product of a vector.
    - On accept: acc <= in_data; count <= 1.
    - The first product loads directly, not 0+x, so the sign of a -0 product is preserved.
    - If in_last, or MAX_LEN==1: go to S_DONE. Otherwise go to S_ACC.
  - S_ACC: on accept, acc <= float_add(acc, in_data); count <= count+1.
    - Go to S_DONE if in_last, or if count+1 == MAX_LEN.
  - S_DONE: in_ready=0; out_valid=1.
    - On output accept: go to S_FIRST; acc and count cleared to 0.
- Output registers (loaded on the same edge that enters S_DONE):
  - out_data <= new acc value; out_count <= new count.
  - out_overflow <= 1 only when the transition was caused by MAX_LEN without in_last. It is 0 when in_last arrives exactly at MAX_LEN.
- Latency:
  - out_valid rises the cycle after the final beat is accepted.
  - Minimum occupancy per vector: N accept cycles plus 1 output cycle.
  - No input beat is accepted during the S_DONE cycle; back-pressure propagates upstream through in_ready.
- out_ready held low: state stays S_DONE; all outputs hold indefinitely.
- Special values: NaN, infinity and denormal handling are whatever float_add produces. The block applies no extra flushing or masking. NaN or inf therefore propagates sticky through the rest of the vector.
- in_valid low in S_FIRST/S_ACC: no state change; gaps between beats are legal at any point.
- Overflow cut: the beat after the cut starts a new vector in S_FIRST once the result is drained.
- Reset mid-vector or mid-output: partial sum discarded, out_valid drops immediately (asynchronous), state S_FIRST.
- Arithmetic width: acc is exactly EXP_WIDTH+MAN_WIDTH+1 bits. count saturates logically at MAX_LEN and never wraps.

Test Plan:
- Sum three products: beats 0x3F800000, 0x40000000, 0x40400000 (last on third), out_ready=1.
  - Expect out_valid one cycle after the third accept; out_data=0x40C00000 (6.0); out_count=3; out_overflow=0; in_ready low for exactly that cycle.
- Single-beat vector with gaps: idle 3 cycles, then 0x3F000000 with in_last.
  - Expect out_data=0x3F000000, out_count=1. A following vector 0x3F800000 + 0x3F000000 gives 0x3FC00000.
- Back-pressure: complete a 2-beat vector with out_ready=0 for 5 cycles while in_valid stays high.
  - Expect in_ready=0, out_data stable and no beats consumed until out_ready rises.
  - Next vector sums correctly.
- Overflow: MAX_LEN=4, five beats of 0x3F800000, in_last only on the fifth.
  - Expect first result 0x40800000, out_count=4, out_overflow=1.
  - Expect second result 0x3F800000, out_count=1, out_overflow=0.
- Special values: 0x3F800000, 0x7F800000, 0x40000000 (last).
  - Expect 0x7F800000. Repeat with 0x7FFFFFFF in the middle: expect a NaN encoding (exponent all ones, mantissa nonzero).
- Reset mid-vector: after 2 of 4 beats, pulse rst_n low for half a cycle.
  - Expect out_valid=0 and outputs 0 immediately.
  - A fresh 0x40000000-last vector then yields 0x40000000, out_count=1.
